usb_tx_packet_ctrl: RTL and testbench

//  Reader side of the shared 64-byte USB data buffer. Frames one USB packet per start request.

---
 rtl/usb_pkg.sv | 37 +++
 rtl/usb_crc16.sv | 40 ++++
 rtl/usb_tx_packet_ctrl.sv | 149 ++++++++++++++
 tb/tb_usb_tx_packet_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// usb_pkg : PID/state encodings and CRC16 constants shared by USB TX/RX. rev 1.0
// ----------------------------------------------------------------------------
package usb_pkg;

  typedef enum logic [3:0] {
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011
  } pid_t;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SYNC   = 4'd1,
    ST_PID    = 4'd2,
    ST_FETCH  = 4'd3,
    ST_LOAD   = 4'd4,
    ST_DATA   = 4'd5,
    ST_CRC_LO = 4'd6,
    ST_CRC_HI = 4'd7,
    ST_EOP    = 4'd8,
    ST_DONE   = 4'd9
  } tx_state_t;

  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;

  // Data-class PIDs all end in 2'b11; handshakes never do.
  function automatic logic is_data_pid(input logic [3:0] pid);
    return (pid[1:0] == 2'b11);
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_crc16.sv
`default_nettype none
// ----------------------------------------------------------------------------
// usb_crc16 : byte-wide reflected CRC16 (0x8005) with clear/enable. rev 1.0
// ----------------------------------------------------------------------------
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // LSB-first fold of one byte; clear wins over enable.
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC16_INIT;
    end else if (en) begin
      for (int i = 0; i < 8; i++) begin
        if (crc_d[0] ^ data[i]) crc_d = (crc_d >> 1) ^ CRC16_POLY_R;
        else                    crc_d = crc_d >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) crc_q <= CRC16_INIT;
    else        crc_q <= crc_d;
  end

  assign crc_out = crc_q;

endmodule
`default_nettype wire

// File: rtl/usb_tx_packet_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// usb_tx_packet_ctrl : frames SYNC?/PID/payload/CRC16/EOP from the TX buffer.
// Option macro USB_TX_SYNC_EN: emit SYNC_BYTE before the PID.       rev 1.0
// ----------------------------------------------------------------------------
module usb_tx_packet_ctrl
  import usb_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64
`ifdef USB_TX_SYNC_EN
  , parameter logic [7:0] SYNC_BYTE = 8'h80
`endif
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [6:0] Buffer_Occupancy,
  input  logic [7:0] TX_Packet_Data,
  output logic       Get_TX_Packet_Data,
  output logic [7:0] tx_byte,
  output logic       tx_byte_valid,
  input  logic       tx_byte_ready,
  output logic       tx_eop,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [6:0] MAX_LEN = 7'(MAX_PAYLOAD);
`ifdef USB_TX_SYNC_EN
  localparam tx_state_t FIRST_ST = ST_SYNC;
`else
  localparam tx_state_t FIRST_ST = ST_PID;
`endif

  tx_state_t   state_q, state_d;
  logic [3:0]  pid_q, pid_d;
  logic [6:0]  rem_q, rem_d;
  logic [7:0]  hold_q, hold_d;
  logic        crc_clr, crc_en;
  logic [15:0] crc;

  usb_crc16 u_crc (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (crc_clr),
    .en      (crc_en),
    .data    (hold_q),
    .crc_out (crc)
  );

  always_comb begin
    state_d            = state_q;
    pid_d              = pid_q;
    rem_d              = rem_q;
    hold_d             = hold_q;
    crc_clr            = 1'b0;
    crc_en             = 1'b0;
    Get_TX_Packet_Data = 1'b0;
    tx_byte            = 8'h00;
    tx_byte_valid      = 1'b0;
    tx_eop             = 1'b0;
    tx_done            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          pid_d   = tx_pid;
          // Length is frozen here; later buffer writes belong to the next packet.
          if (is_data_pid(tx_pid))
            rem_d = (Buffer_Occupancy > MAX_LEN) ? MAX_LEN : Buffer_Occupancy;
          else
            rem_d = 7'd0;
          crc_clr = 1'b1;
          state_d = FIRST_ST;
        end
      end
`ifdef USB_TX_SYNC_EN
      ST_SYNC: begin
        tx_byte       = SYNC_BYTE;
        tx_byte_valid = 1'b1;
        if (tx_byte_ready) state_d = ST_PID;
      end
`endif
      ST_PID: begin
        tx_byte       = {~pid_q, pid_q};
        tx_byte_valid = 1'b1;
        if (tx_byte_ready) begin
          if (!is_data_pid(pid_q)) state_d = ST_EOP;
          else if (rem_q != 7'd0)  state_d = ST_FETCH;
          else                     state_d = ST_CRC_LO;
        end
      end
      ST_FETCH: begin
        Get_TX_Packet_Data = 1'b1;
        state_d            = ST_LOAD;
      end
      ST_LOAD: begin
        hold_d  = TX_Packet_Data;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_byte       = hold_q;
        tx_byte_valid = 1'b1;
        if (tx_byte_ready) begin
          crc_en  = 1'b1;
          rem_d   = rem_q - 7'd1;
          state_d = (rem_q == 7'd1) ? ST_CRC_LO : ST_FETCH;
        end
      end
      ST_CRC_LO: begin
        tx_byte       = ~crc[7:0];
        tx_byte_valid = 1'b1;
        if (tx_byte_ready) state_d = ST_CRC_HI;
      end
      ST_CRC_HI: begin
        tx_byte       = ~crc[15:8];
        tx_byte_valid = 1'b1;
        if (tx_byte_ready) state_d = ST_EOP;
      end
      ST_EOP: begin
        tx_eop = 1'b1;
        if (tx_byte_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        tx_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      pid_q   <= 4'd0;
      rem_q   <= 7'd0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_packet_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_usb_tx_packet_ctrl : scoreboard bench for the USB TX packet framer. rev 1.0
// ----------------------------------------------------------------------------
module tb_usb_tx_packet_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [3:0] tx_pid = 4'd0;
  logic [6:0] Buffer_Occupancy;
  logic [7:0] TX_Packet_Data = 8'd0;
  logic       Get_TX_Packet_Data;
  logic [7:0] tx_byte;
  logic       tx_byte_valid;
  logic       tx_byte_ready = 1'b1;
  logic       tx_eop;
  logic       tx_busy;
  logic       tx_done;

  always #5 clk = ~clk;

  usb_tx_packet_ctrl dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_start           (tx_start),
    .tx_pid             (tx_pid),
    .Buffer_Occupancy   (Buffer_Occupancy),
    .TX_Packet_Data     (TX_Packet_Data),
    .Get_TX_Packet_Data (Get_TX_Packet_Data),
    .tx_byte            (tx_byte),
    .tx_byte_valid      (tx_byte_valid),
    .tx_byte_ready      (tx_byte_ready),
    .tx_eop             (tx_eop),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done)
  );

  // Buffer model: data appears the cycle after a pop strobe.
  logic [7:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign Buffer_Occupancy = 7'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (Get_TX_Packet_Data) begin
      TX_Packet_Data <= mem[rd_ptr % 256];
      rd_ptr         <= rd_ptr + 1;
    end
  end

  // Ready driver: 0 = held high, 1 = toggling, 2 = held low.
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_byte_ready = 1'b1;
      1:       tx_byte_ready = ~tx_byte_ready;
      default: tx_byte_ready = 1'b0;
    endcase
  end

  logic [8:0] exp_q [$];
  int   errors   = 0;
  int   checks   = 0;
  int   get_cnt  = 0;
  int   done_cnt = 0;
  logic sb_en    = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  task automatic push_b(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
  endtask

  task automatic push_eop();
    exp_q.push_back(9'h100);
  endtask

  task automatic monitor();
    logic       hold_chk;
    logic [7:0] held;
    logic [8:0] e;
    logic [8:0] act;
    hold_chk = 1'b0;
    held     = 8'd0;
    forever begin
      @(negedge clk);
      if (tx_done) done_cnt++;
      if (Get_TX_Packet_Data) get_cnt++;
      if (n_rst && sb_en) begin
        if (hold_chk) begin
          chk("hold_valid", {31'd0, tx_byte_valid}, 32'd1);
          chk("hold_byte", {24'd0, tx_byte}, {24'd0, held});
        end
        if ((tx_byte_valid || tx_eop) && tx_byte_ready) begin
          act = tx_eop ? 9'h100 : {1'b0, tx_byte};
          if (tx_eop) chk("eop_no_valid", {31'd0, tx_byte_valid}, 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got %0h expected nothing", act);
          end else begin
            e = exp_q.pop_front();
            chk("sb_out", {23'd0, act}, {23'd0, e});
          end
        end
        hold_chk = tx_byte_valid && !tx_byte_ready;
        held     = tx_byte;
      end else begin
        hold_chk = 1'b0;
      end
    end
  endtask

  task automatic pulse_start(input logic [3:0] pid);
    @(posedge clk); #1;
    tx_pid   = pid;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk(name, {31'd0, done_cnt != d0}, 32'd1);
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_get"},   {31'd0, Get_TX_Packet_Data}, 32'd0);
    chk({tag, "_byte"},  {24'd0, tx_byte}, 32'd0);
    chk({tag, "_valid"}, {31'd0, tx_byte_valid}, 32'd0);
    chk({tag, "_eop"},   {31'd0, tx_eop}, 32'd0);
    chk({tag, "_busy"},  {31'd0, tx_busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, tx_done}, 32'd0);
  endtask

  initial begin
    int          g0;
    int          d0;
    int          n;
    logic [15:0] c;

    fork
      monitor();
    join_none

    #23;
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    n_rst = 1'b1;

    // ACK: PID then EOP, no buffer access
    g0 = get_cnt;
    push_b(8'hD2); push_eop();
    pulse_start(4'b0010);
    wait_done("ack_done");
    chk("ack_sb_empty", exp_q.size(), 32'd0);
    chk("ack_no_get", get_cnt - g0, 32'd0);

    // DATA0 with empty buffer: zero-length CRC
    g0 = get_cnt;
    push_b(8'hC3); push_b(8'h00); push_b(8'h00); push_eop();
    pulse_start(4'b0011);
    wait_done("zlp_done");
    chk("zlp_sb_empty", exp_q.size(), 32'd0);
    chk("zlp_no_get", get_cnt - g0, 32'd0);

    // DATA1 with one byte 00
    mem[wr_ptr % 256] = 8'h00; wr_ptr++;
    g0 = get_cnt;
    push_b(8'h4B); push_b(8'h00); push_b(8'h40); push_b(8'hBF); push_eop();
    pulse_start(4'b1011);
    wait_done("one_done");
    chk("one_sb_empty", exp_q.size(), 32'd0);
    chk("one_gets", get_cnt - g0, 32'd1);
    chk("one_occ", {25'd0, Buffer_Occupancy}, 32'd0);

    // DATA0 with 64 bytes, ready toggling, second start mid-packet
    for (int i = 0; i < 64; i++) begin
      mem[wr_ptr % 256] = 8'(i);
      wr_ptr++;
    end
    c = 16'hFFFF;
    push_b(8'hC3);
    for (int i = 0; i < 64; i++) begin
      push_b(8'(i));
      c = crc_upd(c, 8'(i));
    end
    push_b(~c[7:0]); push_b(~c[15:8]); push_eop();
    g0 = get_cnt;
    d0 = done_cnt;
    ready_mode = 1;
    pulse_start(4'b0011);
    repeat (40) @(posedge clk);
    pulse_start(4'b0010);
    wait_done("full_done");
    repeat (10) @(posedge clk);
    ready_mode = 0;
    chk("full_single_done", done_cnt - d0, 32'd1);
    chk("full_idle", {31'd0, tx_busy}, 32'd0);
    chk("full_sb_empty", exp_q.size(), 32'd0);
    chk("full_gets", get_cnt - g0, 32'd64);
    chk("full_occ", {25'd0, Buffer_Occupancy}, 32'd0);

    // Asynchronous reset while stalled in DATA
    for (int i = 0; i < 4; i++) begin
      mem[wr_ptr % 256] = 8'hA0 + 8'(i);
      wr_ptr++;
    end
    sb_en = 1'b0;
    g0 = get_cnt;
    pulse_start(4'b0011);
    n = 0;
    while (get_cnt == g0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    ready_mode = 2;
    chk("abort_get_seen", {31'd0, get_cnt != g0}, 32'd1);
    repeat (3) @(posedge clk);
    #2;
    chk("abort_in_data_valid", {31'd0, tx_byte_valid}, 32'd1);
    chk("abort_in_data_byte", {24'd0, tx_byte}, 32'hA0);
    #1;
    n_rst = 1'b0;
    #1;
    chk_idle_outputs("abort");
    @(posedge clk); #3;
    chk_idle_outputs("abort_hold");
    n_rst = 1'b1;
    wr_ptr = rd_ptr;
    ready_mode = 0;
    repeat (2) @(posedge clk);
    sb_en = 1'b1;

    // Fresh packet after abort: CRC restarts from FFFF; mid-packet write not sent
    mem[wr_ptr % 256] = 8'h00; wr_ptr++;
    g0 = get_cnt;
    push_b(8'h4B); push_b(8'h00); push_b(8'h40); push_b(8'hBF); push_eop();
    pulse_start(4'b1011);
    repeat (3) @(posedge clk);
    mem[wr_ptr % 256] = 8'h77; wr_ptr++;
    wait_done("post_done");
    chk("post_sb_empty", exp_q.size(), 32'd0);
    chk("post_gets", get_cnt - g0, 32'd1);
    chk("post_occ", {25'd0, Buffer_Occupancy}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
